// File: rtl/timer_countdown.sv
// Countdown timer for the 7-segment display stage.
// Packed time layout: hour[23:16], min[15:8], sec[7:0], all binary.
// Optional feature macro: TIMER_ALARM_TIMEOUT_EN. When it is defined, the
// expired (ALARM) state clears itself after ALARM_SEC one-second ticks.
// When it is undefined, ALARM is held until an accepted button press.
module timer_countdown #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int ALARM_SEC = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  rezhim,
   input  logic        btn_set,
   input  logic        btn_inc,
   input  logic        btn_start,
   output logic [23:0] data_t,
   output logic [1:0]  setup_rezhim_t,
   output logic [23:0] setup_data_t,
   output logic        alarm
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET_H = 3'd1,
      SET_M = 3'd2,
      SET_S = 3'd3,
      RUN   = 3'd4,
      PAUSE = 3'd5,
      ALARM = 3'd6
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [23:0]   preset;
   logic [23:0]   preset_next;
   logic [23:0]   data_next;
   logic [23:0]   setup_next;
   logic          alarm_next;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic          tick;
   logic [23:0]   decremented;

   logic          btn_ok;
   logic          start_p;
   logic          set_p;
   logic          inc_p;

`ifdef TIMER_ALARM_TIMEOUT_EN
   localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

   logic [AW-1:0] alarm_cnt;
   logic [AW-1:0] alarm_cnt_next;
`endif

   // Increment a time field, wrapping back to zero after its maximum.
   function automatic logic [7:0] inc_wrap(input logic [7:0] value, input logic [7:0] max);
      logic [7:0] result;
      if (value >= max) begin
         result = 8'd0;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

   // One-second decrement with borrow from minutes, then from hours.
   function automatic logic [23:0] dec_time(input logic [23:0] t);
      logic [23:0] result;
      if (t[7:0] != 8'd0) begin
         result = {t[23:8], t[7:0] - 8'd1};
      end else if (t[15:8] != 8'd0) begin
         result = {t[23:16], t[15:8] - 8'd1, 8'd59};
      end else begin
         result = {t[23:16] - 8'd1, 8'd59, 8'd59};
      end
      return result;
   endfunction

   // Button qualification: only timer mode listens, and start beats set beats inc.
   always_comb begin
      btn_ok  = (rezhim == 2'd1);
      start_p = btn_ok & btn_start;
      set_p   = btn_ok & btn_set & ~btn_start;
      inc_p   = btn_ok & btn_inc & ~btn_start & ~btn_set;
   end

   // Setup field indicator is a pure decode of the state register.
   always_comb begin
      setup_rezhim_t = 2'd0;
      case (state)
         SET_H:   setup_rezhim_t = 2'd1;
         SET_M:   setup_rezhim_t = 2'd2;
         SET_S:   setup_rezhim_t = 2'd3;
         default: setup_rezhim_t = 2'd0;
      endcase
   end

   // Next-state and datapath decisions; the prescaler idles at 0 unless counting.
   always_comb begin
      state_next  = state;
      data_next   = data_t;
      preset_next = preset;
      setup_next  = setup_data_t;
      alarm_next  = alarm;
      presc_next  = '0;
      tick        = 1'b0;
      decremented = dec_time(data_t);
`ifdef TIMER_ALARM_TIMEOUT_EN
      alarm_cnt_next = '0;
`endif

      case (state)
         IDLE: begin
            if (start_p) begin
               if (data_t != 24'd0) begin
                  state_next = RUN;
               end
            end else if (set_p) begin
               state_next = SET_H;
               setup_next = data_t;
            end
         end

         SET_H: begin
            if (start_p) begin
               state_next = IDLE;
            end else if (set_p) begin
               state_next = SET_M;
            end else if (inc_p) begin
               setup_next[23:16] = inc_wrap(setup_data_t[23:16], 8'd23);
            end
         end

         SET_M: begin
            if (start_p) begin
               state_next = IDLE;
            end else if (set_p) begin
               state_next = SET_S;
            end else if (inc_p) begin
               setup_next[15:8] = inc_wrap(setup_data_t[15:8], 8'd59);
            end
         end

         SET_S: begin
            if (start_p) begin
               state_next = IDLE;
            end else if (set_p) begin
               state_next  = IDLE;
               data_next   = setup_data_t;
               preset_next = setup_data_t;
            end else if (inc_p) begin
               setup_next[7:0] = inc_wrap(setup_data_t[7:0], 8'd59);
            end
         end

         RUN: begin
            tick       = (presc == PRESC_MAX);
            presc_next = tick ? '0 : presc + 1'b1;
            if (tick) begin
               data_next = decremented;
               if (decremented == 24'd0) begin
                  state_next = ALARM;
                  alarm_next = 1'b1;
               end else if (start_p) begin
                  state_next = PAUSE;
               end
            end else if (start_p) begin
               state_next = PAUSE;
            end
         end

         PAUSE: begin
            if (start_p) begin
               state_next = RUN;
            end else if (set_p) begin
               state_next = IDLE;
               data_next  = preset;
            end
         end

         ALARM: begin
            if (start_p | set_p | inc_p) begin
               state_next = IDLE;
               data_next  = preset;
               alarm_next = 1'b0;
            end
`ifdef TIMER_ALARM_TIMEOUT_EN
            else begin
               tick           = (presc == PRESC_MAX);
               presc_next     = tick ? '0 : presc + 1'b1;
               alarm_cnt_next = alarm_cnt;
               if (tick) begin
                  if (alarm_cnt == ALARM_LAST) begin
                     state_next     = IDLE;
                     data_next      = preset;
                     alarm_next     = 1'b0;
                     alarm_cnt_next = '0;
                     presc_next     = '0;
                  end else begin
                     alarm_cnt_next = alarm_cnt + 1'b1;
                  end
               end
            end
`endif
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything including the preset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         data_t       <= 24'd0;
         preset       <= 24'd0;
         setup_data_t <= 24'd0;
         alarm        <= 1'b0;
         presc        <= '0;
      end else begin
         state        <= state_next;
         data_t       <= data_next;
         preset       <= preset_next;
         setup_data_t <= setup_next;
         alarm        <= alarm_next;
         presc        <= presc_next;
      end
   end

`ifdef TIMER_ALARM_TIMEOUT_EN
   // Counts whole seconds spent in ALARM for the auto-timeout.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alarm_cnt <= '0;
      end else begin
         alarm_cnt <= alarm_cnt_next;
      end
   end
`endif

endmodule

// File: tb/tb_timer_countdown.sv
// Directed testbench for timer_countdown with CLK_HZ=4, ALARM_SEC=2.
// Honours TIMER_ALARM_TIMEOUT_EN to pick the ALARM expectations.
module tb_timer_countdown;

   logic        clock;
   logic        reset;
   logic [1:0]  rezhim;
   logic        btn_set;
   logic        btn_inc;
   logic        btn_start;
   logic [23:0] data_t;
   logic [1:0]  setup_rezhim_t;
   logic [23:0] setup_data_t;
   logic        alarm;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [1:0]  rz;
      logic        set;
      logic        inc;
      logic        start;
      int          reps;
      logic [23:0] exp_data;
      logic [1:0]  exp_sr;
      logic [23:0] exp_sd;
      logic        exp_alarm;
   } vec_t;

   vec_t vecs[10];

   timer_countdown #(
      .CLK_HZ    (4),
      .ALARM_SEC (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .rezhim         (rezhim),
      .btn_set        (btn_set),
      .btn_inc        (btn_inc),
      .btn_start      (btn_start),
      .data_t         (data_t),
      .setup_rezhim_t (setup_rezhim_t),
      .setup_data_t   (setup_data_t),
      .alarm          (alarm)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_output(input string name, input logic [23:0] actual, input logic [23:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic wait_clocks(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic [1:0] rz, input logic s, input logic i, input logic st);
      rezhim    = rz;
      btn_set   = s;
      btn_inc   = i;
      btn_start = st;
      wait_clocks(1);
      btn_set   = 1'b0;
      btn_inc   = 1'b0;
      btn_start = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b0;
      #3;
      reset = 1'b1;
      wait_clocks(1);
   endtask

   task automatic program_time(input int h, input int m, input int s);
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
      repeat (h) apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
      repeat (m) apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
      repeat (s) apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      rezhim    = 2'd1;
      btn_set   = 1'b0;
      btn_inc   = 1'b0;
      btn_start = 1'b0;

      //          rz    set   inc   start reps data        sr    sd          alarm
      vecs[0] = '{2'd1, 1'b1, 1'b0, 1'b0, 1,  24'h000000, 2'd1, 24'h000000, 1'b0};
      vecs[1] = '{2'd1, 1'b0, 1'b1, 1'b0, 2,  24'h000000, 2'd1, 24'h020000, 1'b0};
      vecs[2] = '{2'd0, 1'b1, 1'b0, 1'b0, 1,  24'h000000, 2'd1, 24'h020000, 1'b0};
      vecs[3] = '{2'd1, 1'b1, 1'b0, 1'b0, 1,  24'h000000, 2'd2, 24'h020000, 1'b0};
      vecs[4] = '{2'd1, 1'b0, 1'b1, 1'b0, 61, 24'h000000, 2'd2, 24'h020100, 1'b0};
      vecs[5] = '{2'd1, 1'b1, 1'b0, 1'b0, 1,  24'h000000, 2'd3, 24'h020100, 1'b0};
      vecs[6] = '{2'd1, 1'b1, 1'b0, 1'b0, 1,  24'h020100, 2'd0, 24'h020100, 1'b0};
      vecs[7] = '{2'd1, 1'b1, 1'b1, 1'b0, 1,  24'h020100, 2'd1, 24'h020100, 1'b0};
      vecs[8] = '{2'd1, 1'b0, 1'b1, 1'b0, 23, 24'h020100, 2'd1, 24'h010100, 1'b0};
      vecs[9] = '{2'd1, 1'b0, 1'b1, 1'b1, 1,  24'h020100, 2'd0, 24'h010100, 1'b0};

      #12;
      check_output("reset_data", data_t, 24'h0);
      check_output("reset_sr", {22'd0, setup_rezhim_t}, 24'h0);
      check_output("reset_sd", setup_data_t, 24'h0);
      check_output("reset_alarm", {23'd0, alarm}, 24'h0);
      reset = 1'b1;
      wait_clocks(1);

      // Setup walk: field stepping, minute wrap, hour wrap, priority, discard.
      for (int v = 0; v < 10; v++) begin
         repeat (vecs[v].reps)
            apply_stimulus(vecs[v].rz, vecs[v].set, vecs[v].inc, vecs[v].start);
         check_output($sformatf("vec%0d_data", v), data_t, vecs[v].exp_data);
         check_output($sformatf("vec%0d_sr", v), {22'd0, setup_rezhim_t}, {22'd0, vecs[v].exp_sr});
         check_output($sformatf("vec%0d_sd", v), setup_data_t, vecs[v].exp_sd);
         check_output($sformatf("vec%0d_alarm", v), {23'd0, alarm}, {23'd0, vecs[v].exp_alarm});
      end

      // Asynchronous reset mid-RUN, then start is ignored with a zero value.
      do_reset();
      program_time(0, 0, 3);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(2);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_rst_data", data_t, 24'h0);
      check_output("async_rst_sd", setup_data_t, 24'h0);
      #2;
      reset = 1'b1;
      wait_clocks(1);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(6);
      check_output("zero_start_data", data_t, 24'h0);
      check_output("zero_start_alarm", {23'd0, alarm}, 24'h0);

      // Reset mid-setup clears the field indicator.
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      do_reset();
      check_output("setup_rst_sr", {22'd0, setup_rezhim_t}, 24'h0);
      check_output("setup_rst_sd", setup_data_t, 24'h0);

      // Borrow from minutes.
      do_reset();
      program_time(0, 1, 0);
      check_output("preset_0100", data_t, 24'h000100);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(3);
      check_output("borrow_m_hold", data_t, 24'h000100);
      wait_clocks(1);
      check_output("borrow_m", data_t, 24'h00003B);

      // Borrow from hours.
      do_reset();
      program_time(1, 0, 0);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(4);
      check_output("borrow_h", data_t, 24'h003B3B);

      // Expiry and button exit from ALARM.
      do_reset();
      program_time(0, 0, 1);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(3);
      check_output("pre_expire_alarm", {23'd0, alarm}, 24'h0);
      wait_clocks(1);
      check_output("expire_data", data_t, 24'h0);
      check_output("expire_alarm", {23'd0, alarm}, 24'h1);
      apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      check_output("alarm_exit_alarm", {23'd0, alarm}, 24'h0);
      check_output("alarm_exit_data", data_t, 24'h000001);

      // Pause on the tick cycle, resume, pause again, reload.
      do_reset();
      program_time(0, 0, 5);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(3);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      check_output("pause_on_tick", data_t, 24'h000004);
      wait_clocks(12);
      check_output("pause_hold", data_t, 24'h000004);
      apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0);
      check_output("pause_inc_ignored", data_t, 24'h000004);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      wait_clocks(3);
      check_output("resume_hold", data_t, 24'h000004);
      wait_clocks(1);
      check_output("resume_tick", data_t, 24'h000003);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      check_output("pause2", data_t, 24'h000003);
      apply_stimulus(2'd1, 1'b1, 1'b0, 1'b0);
      check_output("reload", data_t, 24'h000005);
      check_output("reload_sr", {22'd0, setup_rezhim_t}, 24'h0);

      // Counting continues while buttons are held outside timer mode.
      do_reset();
      program_time(0, 0, 2);
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      rezhim    = 2'd0;
      btn_set   = 1'b1;
      btn_inc   = 1'b1;
      btn_start = 1'b1;
      wait_clocks(4);
      check_output("rz0_count1", data_t, 24'h000001);
      wait_clocks(4);
      check_output("rz0_count0", data_t, 24'h000000);
      check_output("rz0_alarm", {23'd0, alarm}, 24'h1);
`ifdef TIMER_ALARM_TIMEOUT_EN
      wait_clocks(7);
      check_output("timeout_hold", {23'd0, alarm}, 24'h1);
      wait_clocks(1);
      check_output("timeout_clear", {23'd0, alarm}, 24'h0);
      check_output("timeout_data", data_t, 24'h000002);
`else
      wait_clocks(120);
      check_output("alarm_persist", {23'd0, alarm}, 24'h1);
      check_output("alarm_persist_data", data_t, 24'h0);
      btn_set   = 1'b0;
      btn_inc   = 1'b0;
      btn_start = 1'b0;
      apply_stimulus(2'd1, 1'b0, 1'b0, 1'b1);
      check_output("alarm_btn_clear", {23'd0, alarm}, 24'h0);
      check_output("alarm_btn_data", data_t, 24'h000002);
`endif
      btn_set   = 1'b0;
      btn_inc   = 1'b0;
      btn_start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
